// File: rtl/cp0_ext_if.sv
// MIPS-style CP0 pipeline-side bus: mtc0/mfc0 access, interrupt lines, commit and eret.
// Latency: n/a (signal bundle only).
// Backpressure: none; every strobe is a single-cycle event that the CP0 always accepts.
// master = pipeline/testbench side, slave = cp0_ext.
interface cp0_ext_if #(
    parameter int N_HW_INT = 5
);
    logic                we;          // mtc0 write strobe
    logic [4:0]          r_reg;       // CP0 register select (read and write)
    logic [31:0]         data_in;     // mtc0 write data
    logic [31:0]         data_out;    // mfc0 read data (pre-write value)
    logic [N_HW_INT-1:0] int_;        // external interrupt lines
    logic                exc_req;     // synchronous exception commit request
    logic [4:0]          exc_code;    // ExcCode for exc_req
    logic                exc_bd;      // faulting instruction sits in a delay slot
    logic [31:0]         exc_pc;      // PC of faulting/interrupted instruction
    logic                eret;        // eret commit
    logic                int_out;     // interrupt request to pipeline
    logic [31:0]         exc_vector;  // target PC for the current commit
    logic [31:0]         status_out;
    logic [31:0]         cause_out;
    logic [31:0]         epc_out;

    modport master (
        output we, r_reg, data_in, int_, exc_req, exc_code, exc_bd, exc_pc, eret,
        input  data_out, int_out, exc_vector, status_out, cause_out, epc_out
    );

    modport slave (
        input  we, r_reg, data_in, int_, exc_req, exc_code, exc_bd, exc_pc, eret,
        output data_out, int_out, exc_vector, status_out, cause_out, epc_out
    );
endinterface

// File: rtl/cp0_ext.sv
// CP0 subset: Count/Compare timer, Status, Cause, EPC, interrupt gating and exception commit.
// Latency: reads combinational; writes/commits take effect at the next clk edge; int_ adds one register stage.
// Backpressure: none; mtc0, commit and eret are accepted every cycle (commit > eret > mtc0 on shared fields).
// Ports: clk, rst (synchronous, active-high), bus (cp0_ext_if.slave) carrying the mtc0/mfc0 access,
//        interrupt lines, exception/eret commit inputs, int_out, exc_vector and live Status/Cause/EPC.
module cp0_ext #(
    parameter int                  N_HW_INT  = 5,
    parameter logic [N_HW_INT-1:0] EDGE_MASK = '0,
    parameter int                  COUNT_DIV = 2,
    parameter logic [31:0]         VEC_BASE  = 32'h0000_0180
) (
    input  logic         clk,
    input  logic         rst,
    cp0_ext_if.slave     bus
);

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;

    // Timer state
    logic [31:0] presc;
    logic [31:0] count;
    logic [31:0] compare;
    logic        inc_d;      // Count incremented on the previous edge
    logic        timer_ip;

    // Status fields
    logic        ie;
    logic        exl;
    logic [7:0]  im;

    // Cause fields
    logic        bd;
    logic        iv;
    logic [1:0]  sw_ip;
    logic [4:0]  exc_code_q;

    logic [31:0] epc;

    // Interrupt line sampling
    logic [N_HW_INT-1:0] int_q;
    logic [N_HW_INT-1:0] int_qq;
    logic [N_HW_INT-1:0] edge_ip;

    // Decoded writes
    logic wr_count, wr_compare, wr_status, wr_cause, wr_epc;
    assign wr_count   = bus.we && (bus.r_reg == REG_COUNT);
    assign wr_compare = bus.we && (bus.r_reg == REG_COMPARE);
    assign wr_status  = bus.we && (bus.r_reg == REG_STATUS);
    assign wr_cause   = bus.we && (bus.r_reg == REG_CAUSE);
    assign wr_epc     = bus.we && (bus.r_reg == REG_EPC);

    logic presc_wrap;
    assign presc_wrap = (presc == 32'(COUNT_DIV - 1));

    // Hardware IP bits: edge lines come from the sticky register, level lines straight from the sample.
    logic [N_HW_INT-1:0] hw_ip;
    logic [4:0]          hw_pad;
    logic [7:0]          ip;

    always_comb begin
        hw_ip  = (EDGE_MASK & edge_ip) | (~EDGE_MASK & int_q);
        hw_pad = '0;
        hw_pad[N_HW_INT-1:0] = hw_ip;
        ip = {timer_ip, hw_pad, sw_ip};
    end

    // Sticky edge bits: a fresh rising edge beats a same-cycle software clear.
    logic [N_HW_INT-1:0] rise;
    logic [N_HW_INT-1:0] sw_clr;
    logic [N_HW_INT-1:0] edge_next;

    always_comb begin
        rise      = int_q & ~int_qq;
        sw_clr    = {N_HW_INT{wr_cause}} & ~bus.data_in[10 +: N_HW_INT];
        edge_next = EDGE_MASK & (rise | (edge_ip & ~sw_clr));
    end

    logic [31:0] status_val;
    logic [31:0] cause_val;
    assign status_val = {16'b0, im, 6'b0, exl, ie};
    assign cause_val  = {bd, 7'b0, iv, 7'b0, ip, 1'b0, exc_code_q, 2'b0};

    logic commit;
    logic intr_commit;
    assign bus.int_out  = (|(ip & im)) & ie & ~exl;
    assign commit       = bus.exc_req | bus.int_out;
    assign intr_commit  = ~bus.exc_req & bus.int_out;
    assign bus.exc_vector = (intr_commit && iv) ? (VEC_BASE + 32'h0000_0200) : VEC_BASE;

    assign bus.status_out = status_val;
    assign bus.cause_out  = cause_val;
    assign bus.epc_out    = epc;

    always_comb begin
        case (bus.r_reg)
            REG_COUNT:   bus.data_out = count;
            REG_COMPARE: bus.data_out = compare;
            REG_STATUS:  bus.data_out = status_val;
            REG_CAUSE:   bus.data_out = cause_val;
            REG_EPC:     bus.data_out = epc;
            default:     bus.data_out = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc      <= '0;
            count      <= '0;
            compare    <= '0;
            inc_d      <= 1'b0;
            timer_ip   <= 1'b0;
            ie         <= 1'b0;
            exl        <= 1'b1;
            im         <= '0;
            bd         <= 1'b0;
            iv         <= 1'b0;
            sw_ip      <= '0;
            exc_code_q <= '0;
            epc        <= '0;
            int_q      <= '0;
            int_qq     <= '0;
            edge_ip    <= '0;
        end else begin
            int_q   <= bus.int_;
            int_qq  <= int_q;
            edge_ip <= edge_next;

            // Count: software load restarts the prescaler phase.
            if (wr_count) begin
                count <= bus.data_in;
                presc <= '0;
                inc_d <= 1'b0;
            end else begin
                inc_d <= presc_wrap;
                if (presc_wrap) begin
                    presc <= '0;
                    count <= count + 32'd1;
                end else begin
                    presc <= presc + 32'd1;
                end
            end

            if (wr_compare)
                compare <= bus.data_in;

            // Match is judged on the value an increment produced; a Compare write always wins.
            if (wr_compare)
                timer_ip <= 1'b0;
            else if (inc_d && (count == compare))
                timer_ip <= 1'b1;

            if (wr_status) begin
                ie <= bus.data_in[0];
                im <= bus.data_in[15:8];
            end

            if (commit)
                exl <= 1'b1;
            else if (bus.eret)
                exl <= 1'b0;
            else if (wr_status)
                exl <= bus.data_in[1];

            if (wr_cause) begin
                iv    <= bus.data_in[23];
                sw_ip <= bus.data_in[9:8];
            end

            // Commit owns EPC/BD/ExcCode; nested commits (EXL already set) keep the original EPC/BD.
            if (commit) begin
                exc_code_q <= bus.exc_req ? bus.exc_code : 5'd0;
                if (!exl) begin
                    epc <= bus.exc_bd ? (bus.exc_pc - 32'd4) : bus.exc_pc;
                    bd  <= bus.exc_bd;
                end
            end else if (wr_epc) begin
                epc <= bus.data_in;
            end
        end
    end

endmodule

// File: tb/tb_cp0_ext.sv
module tb_cp0_ext;

    localparam int         NHW   = 5;
    localparam logic [4:0] EMASK = 5'b00001;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cp0_ext_if #(.N_HW_INT(NHW)) bus();

    cp0_ext #(
        .N_HW_INT (NHW),
        .EDGE_MASK(EMASK),
        .COUNT_DIV(2),
        .VEC_BASE (32'h0000_0180)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    // Model state carried between scenarios
    logic [31:0] m_epc;
    logic        m_bd;
    logic [31:0] m_compare;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.we       = 1'b0;
        bus.r_reg    = 5'd0;
        bus.data_in  = 32'h0;
        bus.exc_req  = 1'b0;
        bus.exc_code = 5'd0;
        bus.exc_bd   = 1'b0;
        bus.exc_pc   = 32'h0;
        bus.eret     = 1'b0;
    endtask

    task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
        bus.we      = 1'b1;
        bus.r_reg   = r;
        bus.data_in = d;
        tick();
        bus.we      = 1'b0;
    endtask

    task automatic mfc0(input logic [4:0] r, output logic [31:0] v);
        bus.r_reg = r;
        #1;
        v = bus.data_out;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        mtc0(5'd14, 32'h1234_5678);
        mtc0(5'd12, 32'h0000_FF03);
        // Reset must swallow a same-cycle mtc0, commit and eret.
        rst = 1'b1;
        bus.we = 1'b1; bus.r_reg = 5'd14; bus.data_in = 32'hFFFF_FFFF;
        bus.exc_req = 1'b1; bus.exc_pc = 32'h0000_0100; bus.eret = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        idle_inputs();
        total++; if (bus.status_out !== 32'h0000_0002) begin bad++; $display("FAIL reset_status got=%h exp=%h", bus.status_out, 32'h2); end
        total++; if (bus.cause_out !== 32'h0) begin bad++; $display("FAIL reset_cause got=%h exp=0", bus.cause_out); end
        total++; if (bus.epc_out !== 32'h0) begin bad++; $display("FAIL reset_epc got=%h exp=0", bus.epc_out); end
        total++; if (bus.int_out !== 1'b0) begin bad++; $display("FAIL reset_int_out got=%b exp=0", bus.int_out); end
        mfc0(5'd12, v);
        total++; if (v !== 32'h0000_0002) begin bad++; $display("FAIL reset_mfc0_status got=%h exp=2", v); end
        mfc0(5'd9, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL reset_count got=%h exp=0", v); end
        mfc0(5'd11, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL reset_compare got=%h exp=0", v); end
        m_epc = 32'h0; m_bd = 1'b0; m_compare = 32'h0;
    endtask

    task automatic test_timer;
        int found;
        logic [31:0] v;
        mtc0(5'd11, 32'd5);
        mtc0(5'd9, 32'd0);              // edge W
        found = -1;
        for (int k = 1; k <= 40 && found < 0; k++) begin
            tick();
            if (bus.cause_out[15] === 1'b1) found = k;
        end
        total++; if (found != 11) begin bad++; $display("FAIL timer_set_cycle got=%0d exp=11", found); end
        mfc0(5'd9, v);
        total++; if (v !== 32'd5) begin bad++; $display("FAIL timer_count_at_set got=%0d exp=5", v); end
        mtc0(5'd11, 32'd5);
        total++; if (bus.cause_out[15] !== 1'b0) begin bad++; $display("FAIL timer_clear got=%b exp=0", bus.cause_out[15]); end
        // Compare write landing on the very edge that would set IP[7]
        mtc0(5'd11, 32'd5);
        mtc0(5'd9, 32'd0);              // edge W
        for (int k = 1; k <= 10; k++) tick();
        mtc0(5'd11, 32'd5);             // edge W+11
        total++; if (bus.cause_out[15] !== 1'b0) begin bad++; $display("FAIL timer_same_cycle got=%b exp=0", bus.cause_out[15]); end
        for (int k = 0; k < 4; k++) tick();
        total++; if (bus.cause_out[15] !== 1'b0) begin bad++; $display("FAIL timer_same_cycle_hold got=%b exp=0", bus.cause_out[15]); end
    endtask

    task automatic test_timer_random;
        logic [31:0] start, v;
        int d, found;
        for (int it = 0; it < 5; it++) begin
            start = (it < 2) ? (32'hFFFF_FFF8 + 32'($urandom_range(0, 7))) : $urandom;
            d = int'($urandom_range(1, 12));
            mtc0(5'd9, start);          // edge W0: Count(W0+k) = start + k/2
            mtc0(5'd11, start + 32'(d));
            found = -1;
            v = 32'h0;
            for (int k = 2; k <= 2 * d + 10 && found < 0; k++) begin
                tick();
                if (bus.cause_out[15] === 1'b1) begin
                    found = k;
                    mfc0(5'd9, v);
                end
            end
            total++; if (found != 2 * d + 1) begin bad++; $display("FAIL timer_rand_cycle it=%0d got=%0d exp=%0d", it, found, 2 * d + 1); end
            total++; if (v !== start + 32'(d)) begin bad++; $display("FAIL timer_rand_count it=%0d got=%h exp=%h", it, v, start + 32'(d)); end
        end
        mtc0(5'd9, 32'h0);
        mtc0(5'd11, 32'hFFFF_0000);
        m_compare = 32'hFFFF_0000;
    endtask

    task automatic test_level_random;
        logic [3:0]  p;
        logic [7:0]  im;
        logic        iv;
        logic [31:0] pc;
        logic        exp_int;
        for (int it = 0; it < 10; it++) begin
            p  = 4'($urandom_range(0, 15));
            im = 8'($urandom) & 8'h7F;
            iv = 1'($urandom);
            pc = $urandom & 32'hFFFF_FFFC;
            mtc0(5'd12, 32'h0000_0002);
            mtc0(5'd13, {8'h0, iv, 23'h0});
            bus.int_ = {p, 1'b0};
            tick();
            tick();
            total++; if (bus.cause_out[14:10] !== {p, 1'b0}) begin bad++; $display("FAIL level_ip it=%0d got=%h exp=%h", it, bus.cause_out[14:10], {p, 1'b0}); end
            bus.exc_pc = pc;
            mtc0(5'd12, {16'h0, im, 8'h01});
            exp_int = |({1'b0, p, 3'b000} & im);
            total++; if (bus.int_out !== exp_int) begin bad++; $display("FAIL level_int_out it=%0d got=%b exp=%b", it, bus.int_out, exp_int); end
            total++; if (bus.exc_vector !== ((exp_int && iv) ? 32'h380 : 32'h180)) begin bad++; $display("FAIL level_vector it=%0d got=%h", it, bus.exc_vector); end
            tick();
            if (exp_int) begin
                total++; if (bus.status_out[1] !== 1'b1 || bus.cause_out[6:2] !== 5'd0 || bus.epc_out !== pc) begin
                    bad++; $display("FAIL intr_commit it=%0d status=%h cause=%h epc=%h exp_epc=%h", it, bus.status_out, bus.cause_out, bus.epc_out, pc);
                end
                m_epc = pc; m_bd = 1'b0;
            end else begin
                total++; if (bus.status_out[1] !== 1'b0) begin bad++; $display("FAIL no_commit it=%0d exl=%b exp=0", it, bus.status_out[1]); end
            end
        end
        bus.int_ = '0;
        bus.exc_pc = 32'h0;
        tick();
        tick();
    endtask

    task automatic test_edge_int;
        bus.int_ = '0;
        mtc0(5'd12, 32'h0000_0402);
        mtc0(5'd13, 32'h0);
        tick();
        mtc0(5'd12, 32'h0000_0401);
        total++; if (bus.int_out !== 1'b0) begin bad++; $display("FAIL edge_idle got=%b exp=0", bus.int_out); end
        bus.int_[0] = 1'b1;
        tick();
        bus.int_[0] = 1'b0;
        total++; if (bus.int_out !== 1'b0) begin bad++; $display("FAIL edge_t1 got=%b exp=0", bus.int_out); end
        tick();
        total++; if (bus.int_out !== 1'b1 || bus.cause_out[10] !== 1'b1) begin bad++; $display("FAIL edge_t2 int_out=%b ip2=%b exp=1/1", bus.int_out, bus.cause_out[10]); end
        tick();                         // interrupt commit sets EXL
        total++; if (bus.cause_out[10] !== 1'b1 || bus.int_out !== 1'b0) begin bad++; $display("FAIL edge_sticky ip2=%b int_out=%b exp=1/0", bus.cause_out[10], bus.int_out); end
        mtc0(5'd12, 32'h0000_0401);
        total++; if (bus.int_out !== 1'b1) begin bad++; $display("FAIL edge_rearm got=%b exp=1", bus.int_out); end
        mtc0(5'd13, 32'h0);
        total++; if (bus.cause_out[10] !== 1'b0) begin bad++; $display("FAIL edge_sw_clear got=%b exp=0", bus.cause_out[10]); end
        mtc0(5'd12, 32'h0000_0401);
        total++; if (bus.int_out !== 1'b0) begin bad++; $display("FAIL edge_cleared_int got=%b exp=0", bus.int_out); end
        // Set and software clear on the same edge: set wins
        mtc0(5'd12, 32'h0000_0402);
        bus.int_[0] = 1'b1;
        tick();
        bus.int_[0] = 1'b0;
        bus.we = 1'b1; bus.r_reg = 5'd13; bus.data_in = 32'h0;
        tick();
        bus.we = 1'b0;
        total++; if (bus.cause_out[10] !== 1'b1) begin bad++; $display("FAIL edge_set_vs_clear got=%b exp=1", bus.cause_out[10]); end
        mtc0(5'd13, 32'h0);
        total++; if (bus.cause_out[10] !== 1'b0) begin bad++; $display("FAIL edge_final_clear got=%b exp=0", bus.cause_out[10]); end
    endtask

    task automatic test_exceptions;
        mtc0(5'd12, 32'h0);
        bus.exc_req = 1'b1; bus.exc_code = 5'h0C; bus.exc_bd = 1'b1; bus.exc_pc = 32'h0040_0010;
        #1;
        total++; if (bus.exc_vector !== 32'h0000_0180) begin bad++; $display("FAIL exc_vector got=%h exp=180", bus.exc_vector); end
        tick();
        idle_inputs();
        total++; if (bus.epc_out !== 32'h0040_000C) begin bad++; $display("FAIL exc_bd_epc got=%h exp=0040000c", bus.epc_out); end
        total++; if (bus.cause_out[31] !== 1'b1 || bus.cause_out[6:2] !== 5'h0C) begin bad++; $display("FAIL exc_bd_cause got=%h", bus.cause_out); end
        total++; if (bus.status_out[1] !== 1'b1) begin bad++; $display("FAIL exc_exl got=%b exp=1", bus.status_out[1]); end
        // Nested
        bus.exc_req = 1'b1; bus.exc_code = 5'h04; bus.exc_pc = 32'h0000_1000;
        tick();
        idle_inputs();
        total++; if (bus.epc_out !== 32'h0040_000C || bus.cause_out[31] !== 1'b1 || bus.cause_out[6:2] !== 5'h04) begin
            bad++; $display("FAIL nested epc=%h cause=%h exp_epc=0040000c code=04", bus.epc_out, bus.cause_out);
        end
        // eret colliding with a commit
        bus.exc_req = 1'b1; bus.exc_code = 5'h08; bus.eret = 1'b1;
        tick();
        idle_inputs();
        total++; if (bus.status_out[1] !== 1'b1) begin bad++; $display("FAIL eret_vs_commit exl=%b exp=1", bus.status_out[1]); end
        bus.eret = 1'b1;
        tick();
        idle_inputs();
        total++; if (bus.status_out[1] !== 1'b0) begin bad++; $display("FAIL eret exl=%b exp=0", bus.status_out[1]); end
        // mtc0 EPC colliding with a commit
        bus.exc_req = 1'b1; bus.exc_code = 5'h0A; bus.exc_pc = 32'h0000_2000;
        bus.we = 1'b1; bus.r_reg = 5'd14; bus.data_in = 32'hDEAD_BEEC;
        tick();
        idle_inputs();
        total++; if (bus.epc_out !== 32'h0000_2000 || bus.cause_out[31] !== 1'b0) begin bad++; $display("FAIL mtc0_epc_vs_commit epc=%h bd=%b exp=00002000/0", bus.epc_out, bus.cause_out[31]); end
        // mtc0 Status colliding with a commit: IE/IM from write, EXL from commit
        bus.exc_req = 1'b1; bus.exc_code = 5'h01; bus.exc_pc = 32'h0000_3000;
        bus.we = 1'b1; bus.r_reg = 5'd12; bus.data_in = 32'h0000_5500;
        tick();
        idle_inputs();
        total++; if (bus.status_out !== 32'h0000_5502) begin bad++; $display("FAIL mtc0_status_vs_commit got=%h exp=00005502", bus.status_out); end
        m_epc = 32'h0000_2000; m_bd = 1'b0;
    endtask

    task automatic test_exc_random;
        logic        exl0, bd, er;
        logic [31:0] pc;
        logic [4:0]  code;
        for (int it = 0; it < 12; it++) begin
            exl0 = 1'($urandom);
            bd   = 1'($urandom);
            er   = 1'($urandom);
            pc   = $urandom & 32'hFFFF_FFFC;
            code = 5'($urandom);
            mtc0(5'd12, {30'h0, exl0, 1'b0});
            bus.exc_req = 1'b1; bus.exc_code = code; bus.exc_bd = bd; bus.exc_pc = pc; bus.eret = er;
            #1;
            total++; if (bus.exc_vector !== 32'h0000_0180) begin bad++; $display("FAIL rexc_vector it=%0d got=%h exp=180", it, bus.exc_vector); end
            tick();
            idle_inputs();
            if (!exl0) begin
                m_epc = bd ? pc - 32'd4 : pc;
                m_bd  = bd;
            end
            total++; if (bus.epc_out !== m_epc || bus.cause_out[31] !== m_bd) begin bad++; $display("FAIL rexc_epc it=%0d epc=%h bd=%b exp=%h/%b", it, bus.epc_out, bus.cause_out[31], m_epc, m_bd); end
            total++; if (bus.cause_out[6:2] !== code || bus.status_out[1] !== 1'b1) begin bad++; $display("FAIL rexc_code it=%0d cause=%h exl=%b exp_code=%h", it, bus.cause_out, bus.status_out[1], code); end
        end
    endtask

    task automatic test_regs_random;
        logic [31:0] m_status, d, expv;
        logic [4:0]  r;
        mtc0(5'd12, 32'h0000_0002);
        m_status = 32'h0000_0002;
        for (int it = 0; it < 20; it++) begin
            r = 5'($urandom_range(0, 31));
            if (r == 5'd9 || r == 5'd13) r = 5'd14;
            d = $urandom;
            if (r == 5'd12) d[0] = 1'b0;    // keep IE off so no commits disturb EPC
            case (r)
                5'd11:   expv = m_compare;
                5'd12:   expv = m_status;
                5'd14:   expv = m_epc;
                default: expv = 32'h0;
            endcase
            bus.we = 1'b1; bus.r_reg = r; bus.data_in = d;
            #1;
            total++; if (bus.data_out !== expv) begin bad++; $display("FAIL reg_prewrite r=%0d got=%h exp=%h", r, bus.data_out, expv); end
            tick();
            bus.we = 1'b0;
            case (r)
                5'd11:   m_compare = d;
                5'd12:   m_status  = d & 32'h0000_FF03;
                5'd14:   m_epc     = d;
                default: ;
            endcase
            case (r)
                5'd11:   expv = m_compare;
                5'd12:   expv = m_status;
                5'd14:   expv = m_epc;
                default: expv = 32'h0;
            endcase
            #1;
            total++; if (bus.data_out !== expv) begin bad++; $display("FAIL reg_readback r=%0d got=%h exp=%h", r, bus.data_out, expv); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        bus.int_ = '0;
        tick();
        test_reset();
        test_timer();
        test_timer_random();
        test_level_random();
        test_edge_int();
        test_exceptions();
        test_exc_random();
        test_regs_random();
        test_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cp0_ext.md
CP0_EXT -- requirements
Module: cp0_ext

Interface
REQ-001 The block SHALL have the parameter N_HW_INT, default 5, giving the number of hardware interrupt lines (legal range 1..5), mapped to Cause.IP[2+i].
REQ-002 The block SHALL have the parameter EDGE_MASK [N_HW_INT-1:0], default 0; bit i=1 makes line i edge-triggered and sticky, bit i=0 makes it level-sensitive.
REQ-003 The block SHALL have the parameter COUNT_DIV, default 2, giving the number of clk cycles per Count increment (legal range >=1).
REQ-004 The block SHALL have the parameter VEC_BASE, default 32'h0000_0180, giving the general exception vector.
REQ-005 The block SHALL have the following ports, clock and reset first:
  clk  in  1  single clock, rising edge
  rst  in  1  synchronous, active-high reset
  we  in  1  mtc0 write strobe
  r_reg  in  5  CP0 register select for read and write
  data_in  in  32  mtc0 write data
  data_out  out  32  mfc0 read data
  int_  in  N_HW_INT  external interrupt lines
  exc_req  in  1  synchronous exception commit request
  exc_code  in  5  ExcCode for exc_req
  exc_bd  in  1  faulting instruction is in a delay slot
  exc_pc  in  32  PC of the faulting or interrupted instruction
  eret  in  1  eret commit
  int_out  out  1  interrupt request to pipeline
  exc_vector  out  32  target PC for the current commit
  status_out / cause_out / epc_out  out  32 each  live register values

Function
REQ-006 The block SHALL implement register 9 Count, 11 Compare, 12 Status, 13 Cause and 14 EPC; data_out SHALL be combinational and SHALL show the pre-write value; any other r_reg SHALL read 0 and SHALL ignore writes.
REQ-007 Status SHALL store IE[0], EXL[1] and IM[15:8] as writable bits; all other Status bits SHALL read 0.
REQ-008 Cause SHALL provide BD[31], IV[23] (writable), IP[15:8] and ExcCode[6:2]; IP[1:0] SHALL be software-writable; IP[7] SHALL be the timer pending bit; IP bits above 2+N_HW_INT-1 and below 7 SHALL read 0.
REQ-009 The prescaler SHALL count 0..COUNT_DIV-1; when it wraps, Count SHALL increment by 1, and 32'hFFFF_FFFF SHALL wrap to 0.
REQ-010 An mtc0 write to Count SHALL load data_in and clear the prescaler.
REQ-011 Timer pending IP[7] SHALL be set one cycle after an increment that makes Count equal Compare; it SHALL stay set until an mtc0 write to Compare clears it; a Compare write and a match in the same cycle SHALL leave it clear.
REQ-012 Level lines: int_ SHALL be registered once, and IP[2+i] SHALL follow the registered value.
REQ-013 Edge lines: on a rising edge of registered int_[i], IP[2+i] SHALL set; it SHALL clear only through an mtc0 write of 0 to that bit; a set and a clear in the same cycle SHALL leave the bit set.
REQ-014 int_out SHALL equal |(IP & IM) & IE & ~EXL, combinational from the registered state.
REQ-015 A commit SHALL occur on exc_req=1, or on int_out=1 with exc_req=0, and SHALL update on the next edge as follows:
  ExcCode = exc_req ? exc_code : 0
  EXL = 1
  if EXL was 0: EPC = exc_bd ? exc_pc-4 : exc_pc, and BD = exc_bd
  if EXL was 1: EPC and BD unchanged
REQ-016 exc_vector SHALL be VEC_BASE+32'h200 for an interrupt commit with IV=1, and VEC_BASE otherwise.
REQ-017 eret SHALL clear EXL; when eret and a commit occur in the same cycle, the commit SHALL win.
REQ-018 When mtc0 and a commit occur in the same cycle, the commit SHALL own EPC, EXL, BD and ExcCode, and the mtc0 SHALL update all other fields.

Reset
REQ-019 While rst=1 at a clk edge, the block SHALL set:
  Count=0, Compare=0, prescaler=0
  Status=32'h0000_0002 (EXL=1)
  Cause=0, EPC=0
  int_ sample registers = 0
REQ-020 rst=1 SHALL abort any same-cycle commit, eret or mtc0; after reset, int_out=0 and data_out for r_reg=12 SHALL read 32'h0000_0002.

Verification
REQ-021 Timer: with COUNT_DIV=2, write Compare=5 and Count=0 -> IP[7] sets 11 cycles later; a Compare write then clears IP[7].
REQ-022 Edge interrupt: with EDGE_MASK[0]=1, IM=8'h04 and Status=32'h0000_0401, pulse int_[0] for 1 cycle -> int_out=1 from cycle t+2 until IP[2] is cleared by mtc0.
REQ-023 Delay-slot exception: exc_req=1, exc_code=5'h0C, exc_bd=1, exc_pc=32'h0040_0010 with EXL=0 -> EPC=32'h0040_000C, BD=1, Cause[6:2]=5'h0C, EXL=1, exc_vector=32'h0000_0180.
REQ-024 Nested exception: EXL=1, exc_req with exc_pc=32'h0000_1000 -> EPC unchanged and ExcCode updated.
REQ-025 Vectored interrupt: IV=1 and an interrupt commit -> exc_vector=32'h0000_0380 and ExcCode=0.
REQ-026 Collisions: eret with exc_req in the same cycle -> EXL stays 1; mtc0 to EPC during a commit -> EPC takes the commit value.
